// File: rtl/demultiplexer_buffered_if.sv
// demultiplexer_buffered_if
//   Bundles the producer stream and the two consumer streams of
//   demultiplexer_buffered.
//   Parameter: inputWidth - data width of in, out0 and out1.
//   Signals:
//     in, inValid, select    producer word, its valid flag and its destination
//     inReady                block accepts the producer transfer this cycle
//     out0/out1              head word of FIFO 0 / FIFO 1
//     out0Valid/out1Valid    FIFO 0 / FIFO 1 is non-empty
//     out0Ready/out1Ready    sink 0 / sink 1 consumes the head word
//   Modports: slave is the block's view, master is the producer/sink side.
interface demultiplexer_buffered_if #(
    parameter int inputWidth = 8
);
    logic [inputWidth-1:0] in;
    logic                  inValid;
    logic                  inReady;
    logic                  select;
    logic [inputWidth-1:0] out0;
    logic                  out0Valid;
    logic                  out0Ready;
    logic [inputWidth-1:0] out1;
    logic                  out1Valid;
    logic                  out1Ready;

    modport slave (
        input  in, inValid, select, out0Ready, out1Ready,
        output inReady, out0, out0Valid, out1, out1Valid
    );

    modport master (
        output in, inValid, select, out0Ready, out1Ready,
        input  inReady, out0, out0Valid, out1, out1Valid
    );
endinterface

// File: rtl/demultiplexer_buffered.sv
// demultiplexer_buffered
//   Distributes one producer stream to two sinks. Each sink owns a 2-entry
//   FIFO so a stalled sink never blocks traffic to the other one.
//   Ports:
//     clk      rising-edge clock
//     rst_n    asynchronous active-low reset; clears FIFOs and outputs
//     bus      demultiplexer_buffered_if.slave (producer + both sinks)
//     count0/count1  saturating push counters, only when DEMUX_STATS_EN
//   Optional feature macro: DEMUX_STATS_EN (default build: undefined).
module demultiplexer_buffered #(
    parameter int inputWidth = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    demultiplexer_buffered_if.slave  bus
`ifdef DEMUX_STATS_EN
    ,
    output logic [7:0]               count0,
    output logic [7:0]               count1
`endif
);

    logic [inputWidth-1:0] mem [2][2];
    logic [1:0]            occ [2];
    logic [1:0]            rptr;
    logic [1:0]            wptr;

    logic [1:0] full;
    logic [1:0] out_ready;
    logic [1:0] sel_hot;
    logic [1:0] push;
    logic [1:0] pop;
    logic       ready;

    // inReady looks only at select and registered occupancy; the sink
    // ready lines never feed it, so a full FIFO refuses even when draining.
    always_comb begin
        full      = {occ[1] == 2'd2, occ[0] == 2'd2};
        out_ready = {bus.out1Ready, bus.out0Ready};
        sel_hot   = {bus.select, ~bus.select};
        ready     = ~full[bus.select];
        push      = {2{bus.inValid & ready}} & sel_hot;
        pop       = {occ[1] != 2'd0, occ[0] != 2'd0} & out_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                occ[i]    <= 2'd0;
                mem[i][0] <= '0;
                mem[i][1] <= '0;
            end
            rptr <= 2'b00;
            wptr <= 2'b00;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (push[i]) begin
                    mem[i][wptr[i]] <= bus.in;
                    wptr[i]         <= ~wptr[i];
                end
                if (pop[i]) begin
                    rptr[i] <= ~rptr[i];
                end
                case ({push[i], pop[i]})
                    2'b10:   occ[i] <= occ[i] + 2'd1;
                    2'b01:   occ[i] <= occ[i] - 2'd1;
                    default: occ[i] <= occ[i];
                endcase
            end
        end
    end

    // The head entry is only overwritten when it is not the live head, so
    // outN stays stable while a sink stalls. Storage is cleared on reset
    // so both outputs read 0 immediately.
    assign bus.inReady   = ready;
    assign bus.out0      = mem[0][rptr[0]];
    assign bus.out1      = mem[1][rptr[1]];
    assign bus.out0Valid = (occ[0] != 2'd0);
    assign bus.out1Valid = (occ[1] != 2'd0);

`ifdef DEMUX_STATS_EN
    logic [7:0] cnt [2];

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt[0] <= 8'd0;
            cnt[1] <= 8'd0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (push[i]) begin
                    cnt[i] <= sat_inc(cnt[i]);
                end
            end
        end
    end

    assign count0 = cnt[0];
    assign count1 = cnt[1];
`endif

endmodule

// File: doc/demultiplexer_buffered.md
# demultiplexer_buffered

Routes one 8-bit (parameterisable) producer stream to one of two consumer ports, chosen per transfer by `select`. It is the inverse of the datapath `Multiplexer`: where the mux merges two sources onto one bus, this block distributes one bus to two sinks. Each sink has its own 2-entry FIFO, so a stalled sink does not block traffic to the other. It sits between the register-file write bus and the two downstream destination registers or ports.

## Interface
- `inputWidth`, default 8: data width of the input and both output ports.

- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  asynchronous, active-low reset.
- `in`  input  inputWidth  input data word.
- `inValid`  input  1  `in` and `select` hold a valid transfer.
- `inReady`  output  1  block accepts the transfer this cycle.
- `select`  input  1  destination: 0 sends to `out0`, 1 sends to `out1`.
- `out0` / `out1`  output  inputWidth  head word of FIFO 0 / FIFO 1.
- `out0Valid` / `out1Valid`  output  1  FIFO 0 / 1 is non-empty.
- `out0Ready` / `out1Ready`  input  1  sink 0 / 1 consumes the head word this cycle.
- `count0` / `count1`  output  8  saturating transfer counters; present only with `DEMUX_STATS_EN`.

## Operation
- Two independent FIFOs, depth 2, each with a 2-bit occupancy count (0..2), a 1-bit read pointer and a 1-bit write pointer.
- Push: `inValid && inReady` at a rising edge writes `in` into FIFO[`select`].
- `inReady = (occupancy[select] != 2)`. It is combinational from `select` and registered state only, never from `outNReady`. There is no pass-through when the FIFO is full.
- Pop: `outNValid && outNReady` at a rising edge advances the FIFO N read pointer.
- `outN` is driven from the FIFO N entry at the read pointer. `outN` holds its value while `outNValid && !outNReady`.
- Push and pop on the same FIFO in the same cycle: occupancy is unchanged. This is legal at occupancy 1. At occupancy 2 the push is blocked because `inReady` = 0, so only the pop happens. At occupancy 0 only the push happens.
- Each FIFO preserves order. There is no ordering relation between the two FIFOs.
- `select` may change on any cycle. Only its value in a cycle where `inValid` is high matters.
- Pointers wrap modulo 2.
- Reset, including mid-operation: all FIFO contents are discarded, and occupancies, pointers, `out0`, `out1` and `outNValid` clear to 0. While reset is low, `inReady` = 1.

## Timing
- Latency: a word pushed at edge k appears on `outN` with `outNValid` = 1 after edge k. It can be popped no earlier than edge k+1.
- Throughput: one transfer per cycle into a FIFO that is being drained every cycle. Into an undrained FIFO, at most 2 back-to-back pushes before `inReady` drops.
- `outNValid` and `outN` are registered, with no combinational path from the inputs.
- Reset values: `out0` = `out1` = 0, `out0Valid` = `out1Valid` = 0, `count0` = `count1` = 0.

## Configuration
- `DEMUX_STATS_EN` defined:
  - The `count0` and `count1` ports and registers exist.
  - `countN` increments by 1 on each push into FIFO N and saturates at 255.
  - Reset sets both counters to 0.
  - Counter updates are registered, visible the cycle after the push.
- `DEMUX_STATS_EN` undefined: the ports and counter logic are absent. All other behaviour is identical.

## Test plan
- Reset, then push `in`=FF, `select`=0 -> next cycle `out0`=FF, `out0Valid`=1, `out1Valid`=0. Pop with `out0Ready`=1 -> `out0Valid`=0.
- Hold `out1Ready`=0, push AA then 55 with `select`=1 -> `inReady`=0 while `select`=1 and 1 while `select`=0. Then raise `out1Ready` -> `out1` reads AA then 55.
- With FIFO 0 at occupancy 1 and `out0Ready`=1, push continuously 01,02,03 with `select`=0 -> occupancy stays 1, words emerge in order, and `inReady` stays 1.
- Alternate `select` 0/1 on consecutive pushes of 10,11,12,13 with both sinks ready -> `out0` sees 10,12 and `out1` sees 11,13, one cycle after each push.
- Fill both FIFOs, assert `rst_n`=0 mid-cycle -> `out0Valid`=`out1Valid`=0 and `out0`=`out1`=0 immediately. After release, the first push is delivered with no stale data.
- With `DEMUX_STATS_EN`, do 300 pushes to port 1 and 3 to port 0 -> `count1`=255 and `count0`=3.
